// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The trap-on-misaligned-redirect build is selected with MISALIGN_TRAP_EN.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HAVE = 2'd1,
    S_DROP = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] PC_INC             = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/if_next_pc.sv
// Combinational redirect detection, target selection and sequential PC+4.
// With MISALIGN_TRAP_EN a misaligned target is replaced by EXC_VECTOR.
module if_next_pc
  import if_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [31:0] Jump_target,
  output logic        redirect,
  output logic [31:0] target,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] pc_plus4
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [31:0] raw_target;
  logic        bad_align;

  // The branch is the older instruction, so it wins over a same-cycle jump.
  always_comb begin
    redirect   = Branch_taken | Jump;
    raw_target = Branch_taken ? Branch_target : Jump_target;
    bad_align  = |raw_target[1:0];
    if (TRAP_EN && bad_align) begin
      target = EXC_VECTOR;
    end else begin
      target = {raw_target[31:2], 2'b00};
    end
    pc_plus4 = pc + PC_INC;
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = redirect & bad_align;
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ready FSM and stall buffer.
// Optional MISALIGN_TRAP_EN adds the IF_misalign output and trap redirection.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  input  logic        Jump,
  input  logic [31:0] Jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_IF,
  output logic [31:0] PC_Address_next,
  output logic        IF_valid,
`ifdef MISALIGN_TRAP_EN
  output logic        IF_misalign,
`endif
  output logic [31:0] PC_current
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        mem_hit;

  if_next_pc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc (
    .pc           (pc_q),
    .Branch_taken (Branch_taken),
    .Branch_target(Branch_target),
    .Jump         (Jump),
    .Jump_target  (Jump_target),
    .redirect     (redirect),
    .target       (target),
`ifdef MISALIGN_TRAP_EN
    .misalign     (IF_misalign),
`endif
    .pc_plus4     (pc_plus4)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_q       <= NOP_INSTR;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // A response arriving while reset is held must never reach IF/ID.
  assign mem_hit = imem_ready & reset;

  // Redirects take priority over PCWrite; a stale response is dropped by
  // remembering the old address in drop_addr_q until memory answers it.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    drop_addr_d    = drop_addr_q;
    imem_req       = 1'b0;
    imem_addr      = pc_q;
    IF_valid       = 1'b0;
    Instruction_IF = NOP_INSTR;

    unique case (state_q)
      S_REQ: begin
        imem_req = reset;
        if (mem_hit) begin
          IF_valid       = 1'b1;
          Instruction_IF = imem_rdata;
          if (redirect) begin
            pc_d = target;
          end else if (PCWrite) begin
            pc_d = pc_plus4;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_HAVE;
          end
        end else if (redirect) begin
          pc_d        = target;
          drop_addr_d = pc_q;
          state_d     = S_DROP;
        end
      end
      S_HAVE: begin
        IF_valid       = 1'b1;
        Instruction_IF = buf_q;
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (PCWrite) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        imem_req  = reset;
        imem_addr = drop_addr_q;
        if (redirect) begin
          pc_d = target;
        end
        if (mem_hit) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign PC_Address_next = pc_plus4;
  assign PC_current      = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage; honours MISALIGN_TRAP_EN.
module tb_if_fetch_stage;

  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        Jump;
  logic [31:0] Jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_Address_next;
  logic        IF_valid;
  logic [31:0] PC_current;
`ifdef MISALIGN_TRAP_EN
  logic        IF_misalign;
  localparam logic [31:0] MIS_PC  = 32'h0000_0180;
  localparam logic        MIS_EXP = 1'b1;
`else
  localparam logic [31:0] MIS_PC  = 32'h0000_0100;
  localparam logic        MIS_EXP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  if_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .PCWrite        (PCWrite),
    .Branch_taken   (Branch_taken),
    .Branch_target  (Branch_target),
    .Jump           (Jump),
    .Jump_target    (Jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .Instruction_IF (Instruction_IF),
    .PC_Address_next(PC_Address_next),
    .IF_valid       (IF_valid),
`ifdef MISALIGN_TRAP_EN
    .IF_misalign    (IF_misalign),
`endif
    .PC_current     (PC_current)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic pcw,
                               input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt,
                               input logic rdy, input logic [31:0] rd,
                               input logic ereq, input logic [31:0] eaddr,
                               input logic evalid, input logic [31:0] einstr,
                               input logic [31:0] epc, input logic emis);
    exp_t e;
    PCWrite       = pcw;
    Branch_taken  = br;
    Branch_target = bt;
    Jump          = jp;
    Jump_target   = jt;
    imem_ready    = rdy;
    imem_rdata    = rd;
    e.tag   = tag;
    e.req   = ereq;
    e.addr  = eaddr;
    e.valid = evalid;
    e.instr = einstr;
    e.pc    = epc;
    e.mis   = emis;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clock);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "imem_req", {31'b0, imem_req}, {31'b0, e.req});
      cmp(e.tag, "imem_addr", imem_addr, e.addr);
      cmp(e.tag, "IF_valid", {31'b0, IF_valid}, {31'b0, e.valid});
      cmp(e.tag, "Instruction_IF", Instruction_IF, e.instr);
      cmp(e.tag, "PC_Address_next", PC_Address_next, e.pc + 32'd4);
      cmp(e.tag, "PC_current", PC_current, e.pc);
`ifdef MISALIGN_TRAP_EN
      cmp(e.tag, "IF_misalign", {31'b0, IF_misalign}, {31'b0, e.mis});
`endif
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    PCWrite = 1'b0; Branch_taken = 1'b0; Branch_target = '0;
    Jump = 1'b0; Jump_target = '0; imem_ready = 1'b0; imem_rdata = '0;
    @(posedge clock);
    #1;

    // Reset state, with a spurious ready that must be ignored.
    applyStimulus("rst", 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    checkOutput();
    reset = 1'b1;

    // Zero-wait streaming.
    applyStimulus("zw0", 1, 0, 0, 0, 0, 1, word(32'h0), 1, 32'h0, 1, word(32'h0), 32'h0, 0);
    checkOutput();
    applyStimulus("zw4", 1, 0, 0, 0, 0, 1, word(32'h4), 1, 32'h4, 1, word(32'h4), 32'h4, 0);
    checkOutput();

    // Stall at PC=8 for three cycles, then resume.
    applyStimulus("stall0", 0, 0, 0, 0, 0, 1, 32'h8C01_0004, 1, 32'h8, 1, 32'h8C01_0004, 32'h8, 0);
    checkOutput();
    applyStimulus("stall1", 0, 0, 0, 0, 0, 1, word(32'h99), 0, 32'h8, 1, 32'h8C01_0004, 32'h8, 0);
    checkOutput();
    applyStimulus("stall2", 0, 0, 0, 0, 0, 1, word(32'h99), 0, 32'h8, 1, 32'h8C01_0004, 32'h8, 0);
    checkOutput();
    applyStimulus("unstall", 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h8, 1, 32'h8C01_0004, 32'h8, 0);
    checkOutput();
    applyStimulus("after", 1, 0, 0, 0, 0, 1, word(32'hC), 1, 32'hC, 1, word(32'hC), 32'hC, 0);
    checkOutput();

    // Slow memory at PC=16, branch during the first wait cycle.
    applyStimulus("wait_br", 1, 1, 32'h40, 0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h0, 32'h10, 0);
    checkOutput();
    applyStimulus("drop_w", 1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h0, 32'h40, 0);
    checkOutput();
    applyStimulus("drop_r", 1, 0, 0, 0, 0, 1, 32'hBAD0_0010, 1, 32'h10, 0, 32'h0, 32'h40, 0);
    checkOutput();
    applyStimulus("tgt_w", 1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h40, 0, 32'h0, 32'h40, 0);
    checkOutput();
    applyStimulus("tgt_hit", 1, 0, 0, 0, 0, 1, word(32'h40), 1, 32'h40, 1, word(32'h40), 32'h40, 0);
    checkOutput();

    // Branch and jump together: branch target wins.
    applyStimulus("br_jp", 1, 1, 32'h100, 1, 32'h200, 1, word(32'h44), 1, 32'h44, 1, word(32'h44), 32'h44, 0);
    checkOutput();
    applyStimulus("prio", 1, 0, 0, 0, 0, 1, word(32'h100), 1, 32'h100, 1, word(32'h100), 32'h100, 0);
    checkOutput();

    // Misaligned jump target.
    applyStimulus("mis_jp", 1, 0, 0, 1, 32'h102, 1, word(32'h104), 1, 32'h104, 1, word(32'h104), 32'h104, MIS_EXP);
    checkOutput();
    applyStimulus("mis_land", 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, MIS_PC, 1, 32'h1234_5678, MIS_PC, 0);
    checkOutput();
    applyStimulus("have", 0, 0, 0, 0, 0, 1, word(32'h7), 0, MIS_PC, 1, 32'h1234_5678, MIS_PC, 0);
    checkOutput();

    // Reset asserted while holding a buffered instruction.
    reset = 1'b0;
    applyStimulus("rst_have", 1, 0, 0, 0, 0, 1, word(32'h7), 0, 32'h0, 0, 32'h0, 32'h0, 0);
    checkOutput();
    applyStimulus("rst_hold", 1, 0, 0, 0, 0, 1, word(32'h7), 0, 32'h0, 0, 32'h0, 32'h0, 0);
    checkOutput();
    reset = 1'b1;

    // Restart from RESET_PC, then jump to the top of memory and wrap.
    applyStimulus("post_rst", 1, 0, 0, 1, 32'hFFFF_FFFC, 1, word(32'h0), 1, 32'h0, 1, word(32'h0), 32'h0, 0);
    checkOutput();
    applyStimulus("wrap", 1, 0, 0, 0, 0, 1, word(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1, word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0);
    checkOutput();
    applyStimulus("wrapped", 1, 0, 0, 0, 0, 1, word(32'h0), 1, 32'h0, 1, word(32'h0), 32'h0, 0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
